serial_add_ctrl: RTL

- Bit-serial adder controller that reuses one full-adder cell for an N-bit addition.
- Each cycle, the controller feeds one bit pair LSB-first plus the stored carry into the cell, then shifts the result into a sum register.
- Start/busy/done handshake toward the requesting logic.
- Trades latency (WIDTH+1 cycles) for area. Sits between operand-producing logic and a single-cell arithmetic datapath.

---
 rtl/serial_add_defs.sv | 11 +
 rtl/fa_cell.sv | 18 +
 rtl/half_adder.sv | 12 +
 rtl/serial_add_ctrl.sv | 104 ++++++++++
 4 files changed

// File: rtl/serial_add_defs.sv
// Shared constants for the bit-serial adder controller: FSM encoding and
// default operand width.
package serial_add_defs;

  localparam int WIDTH_DEF = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

endpackage

// File: rtl/fa_cell.sv
// Full-adder cell built from two half adders; the one arithmetic cell
// reused every cycle by serial_add_ctrl.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s0, c0, c1;

  half_adder u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
  half_adder u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

  assign co = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder, building block of fa_cell.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one fa_cell processes operand bits LSB-first over WIDTH
// cycles, with a start/busy/done handshake around the computation.
module serial_add_ctrl
  import serial_add_defs::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             fa_s, fa_co;

  fa_cell u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at LSB.
        res_sh_d = {fa_s, res_sh_q[WIDTH-1:1]};
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d  = fa_co;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          sum_d   = {fa_s, res_sh_q[WIDTH-1:1]};
          cout_d  = fa_co;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
